// File: rtl/lfsr_decrypt_dp_if.sv
// Byte-stream interface of the LFSR decrypt datapath: encrypted input, plaintext
// output and the recovered-key / packet status signals.
interface lfsr_decrypt_dp_if #(
    parameter int unsigned W = 5
);
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] seed_found;
    logic [W-1:0] taps_found;
    logic         taps_valid;
    logic         pkt_done;
    logic         err;
    logic [5:0]   byte_cnt;

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, out_byte, out_valid, seed_found, taps_found,
               taps_valid, pkt_done, err, byte_cnt
    );

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, out_byte, out_valid, seed_found, taps_found,
               taps_valid, pkt_done, err, byte_cnt
    );
endinterface

// File: rtl/lfsr_decrypt_dp.sv
// Receive side of the LFSR byte cipher: recovers seed and taps from the known
// preamble of each packet, then decrypts and forwards the message bytes.
module lfsr_decrypt_dp #(
    parameter int unsigned W        = 5,
    parameter int unsigned PKT_LEN  = 32,
    parameter logic [7:0]  PRE_CHAR = 8'h5F
) (
    input  logic             clk,
    input  logic             rst,
    lfsr_decrypt_dp_if.slave bus
);
    localparam int unsigned NT = 1 << W;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {IDLE, PRE, MSG, ERR} state_t;

    state_t        state;
    logic [W-1:0]  s;
    logic [NT-1:1] mask;
    logic [W-1:0]  seed_q;
    logic [W-1:0]  taps_q;
    logic          taps_valid_q;
    logic          pkt_done_q;
    logic          err_q;
    logic [CW-1:0] cnt;
    logic [7:0]    out_byte_q;
    logic          out_valid_q;

    logic [W-1:0]  obs;
    logic [W-1:0]  lowest;
    logic [W-1:0]  tsel;
    logic [W-1:0]  s_dec;
    logic [NT-1:1] mask_pruned;
    logic [7:0]    dec;
    logic [CW-1:0] cnt_inc;
    logic          found;
    logic          hdr_ok;
    logic          ready;
    logic          accept;
    logic          last;

    function automatic logic [W-1:0] step(input logic [W-1:0] st, input logic [W-1:0] tp);
        return {st[W-2:0], ^(st & tp)};
    endfunction

    assign obs     = bus.in_byte[W-1:0] ^ PRE_CHAR[W-1:0];
    assign hdr_ok  = !bus.in_byte[7] && (bus.in_byte[6:5] == PRE_CHAR[6:5]);
    assign cnt_inc = cnt + CW'(1);
    assign last    = (cnt_inc == CW'(PKT_LEN));
    assign tsel    = (state == PRE) ? lowest : taps_q;
    assign s_dec   = step(s, tsel);

    // Prune every tap candidate in parallel; the descending scan leaves the lowest survivor.
    always_comb begin
        found       = 1'b0;
        lowest      = '0;
        mask_pruned = '0;
        for (int t = int'(NT) - 1; t >= 1; t--) begin
            mask_pruned[t] = mask[t] && (step(s, W'(t)) == obs);
            if (mask[t]) begin
                found  = 1'b1;
                lowest = W'(t);
            end
        end
    end

    always_comb begin
        dec          = bus.in_byte;
        dec[7]       = 1'b0;
        dec[W-1:0]   = bus.in_byte[W-1:0] ^ s_dec;
    end

    // Message bytes wait for room in the output register; an error that lands on the
    // final byte holds off input for the one cycle ERR needs to return to IDLE.
    always_comb begin
        ready = 1'b1;
        if (state == MSG || (state == PRE && bus.in_byte[7]))
            ready = !out_valid_q || bus.out_ready;
        if (state == ERR && cnt == CW'(PKT_LEN))
            ready = 1'b0;
    end

    assign accept = bus.in_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s            <= '0;
            mask         <= '1;
            seed_q       <= '0;
            taps_q       <= '0;
            taps_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            err_q        <= 1'b0;
            cnt          <= '0;
            out_byte_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            if (out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        cnt          <= CW'(1);
                        mask         <= '1;
                        taps_valid_q <= 1'b0;
                        if (hdr_ok) begin
                            s      <= obs;
                            seed_q <= obs;
                            state  <= PRE;
                        end else begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                PRE: if (accept) begin
                    cnt <= cnt_inc;
                    if (!bus.in_byte[7]) begin
                        if (!hdr_ok) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else begin
                            mask <= mask_pruned;
                            s    <= obs;
                            if (last)
                                state <= IDLE;
                        end
                    end else if (!found || cnt == CW'(1)) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end else begin
                        taps_q       <= lowest;
                        taps_valid_q <= 1'b1;
                        s            <= s_dec;
                        out_byte_q   <= dec;
                        out_valid_q  <= 1'b1;
                        state        <= last ? IDLE : MSG;
                        pkt_done_q   <= last;
                    end
                end
                MSG: if (accept) begin
                    cnt <= cnt_inc;
                    if (!bus.in_byte[7]) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end else begin
                        s           <= s_dec;
                        out_byte_q  <= dec;
                        out_valid_q <= 1'b1;
                        if (last) begin
                            state      <= IDLE;
                            pkt_done_q <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    if (cnt == CW'(PKT_LEN)) begin
                        state <= IDLE;
                        err_q <= 1'b0;
                        cnt   <= '0;
                    end else if (accept) begin
                        cnt <= cnt_inc;
                        if (last) begin
                            state <= IDLE;
                            err_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_byte   = out_byte_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.seed_found = seed_q;
    assign bus.taps_found = taps_q;
    assign bus.taps_valid = taps_valid_q;
    assign bus.pkt_done   = pkt_done_q;
    assign bus.err        = err_q;
    assign bus.byte_cnt   = cnt;
endmodule

// File: tb/tb_lfsr_decrypt_dp.sv
// Directed bench for lfsr_decrypt_dp: encrypts known packets with a reference
// LFSR encoder and checks the recovered key, plaintext and error handling.
module tb_lfsr_decrypt_dp;
    logic clk = 1'b0;
    logic rst;

    lfsr_decrypt_dp_if #(.W(5)) bus ();

    lfsr_decrypt_dp #(.W(5), .PKT_LEN(32), .PRE_CHAR(8'h5F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         npkt   = 0;
    int         nvalid = 0;
    logic [7:0] rx [$];
    logic [7:0] pkt [32];
    string      msg24 = "ABCDEFGHIJKLMNOPQRSTUVWX";
    string      msg31 = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcde";

    // Output-side monitor: records every delivered byte and counts pulses.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) rx.push_back(bus.out_byte);
            if (bus.out_valid) nvalid <= nvalid + 1;
            if (bus.pkt_done)  npkt   <= npkt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: byte k XORs its low 5 bits with LFSR state s_k.
    task automatic build(input logic [4:0] seed, input logic [4:0] taps, input int npre, input string msg);
        logic [4:0] s;
        logic [7:0] p;
        s = seed;
        for (int k = 0; k < 32; k++) begin
            if (k < npre) p = 8'h5F;
            else          p = msg[k-npre] | 8'h80;
            pkt[k] = {p[7:5], p[4:0] ^ s};
            s = {s[3:0], ^(s & taps)};
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        bus.in_byte  = b;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check("in_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_stall(input logic [7:0] b, input logic [7:0] held);
        bus.out_ready = 1'b0;
        bus.in_byte   = b;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_byte_0", 32'(bus.out_byte), 32'(held));
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready_5", 32'(bus.in_ready), 32'd0);
        check("stall_byte_5", 32'(bus.out_byte), 32'(held));
        check("stall_valid_5", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input int lo, input int hi, input int stall, input logic [7:0] held);
        for (int i = lo; i < hi; i++) begin
            if (i == stall) do_stall(pkt[i], held);
            send_byte(pkt[i]);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_rx(input string tag, input string msg, input int n);
        check({tag, "_len"}, 32'(rx.size()), 32'(n));
        for (int i = 0; i < n && i < rx.size(); i++) begin
            logic [7:0] e;
            e = msg[i];
            check($sformatf("%s_byte%0d", tag, i), 32'(rx[i]), 32'(e));
        end
        rx.delete();
    endtask

    initial begin
        int p0;
        int v0;
        rst           = 1'b1;
        bus.in_byte   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_taps_valid", 32'(bus.taps_valid), 32'd0);
        check("rst_byte_cnt", 32'(bus.byte_cnt), 32'd0);

        // Good packet: seed 01, taps 12, 8-byte preamble.
        build(5'h01, 5'h12, 8, msg24);
        send_range(0, 1, -1, 8'h00);
        check("g1_seed_early", 32'(bus.seed_found), 32'h01);
        check("g1_byte_cnt_1", 32'(bus.byte_cnt), 32'd1);
        send_range(1, 32, -1, 8'h00);
        check("g1_byte_cnt_32", 32'(bus.byte_cnt), 32'd32);
        check("g1_pkt_done", 32'(bus.pkt_done), 32'd1);
        @(posedge clk);
        #1;
        check("g1_pkt_done_clr", 32'(bus.pkt_done), 32'd0);
        check("g1_byte_cnt_clr", 32'(bus.byte_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("g1_seed", 32'(bus.seed_found), 32'h01);
        check("g1_taps", 32'(bus.taps_found), 32'h12);
        check("g1_taps_valid", 32'(bus.taps_valid), 32'd1);
        check("g1_npkt", 32'(npkt), 32'd1);
        check_rx("g1", msg24, 24);

        // Backpressure at message byte 10; taps_valid holds until the next first byte.
        send_range(0, 1, -1, 8'h00);
        check("bp_taps_valid_clr", 32'(bus.taps_valid), 32'd0);
        send_range(1, 32, 17, 8'h49);
        repeat (3) @(posedge clk);
        #1;
        check("bp_npkt", 32'(npkt), 32'd2);
        check_rx("bp", msg24, 24);

        // One-byte preamble: error at byte 2, discard to byte 32.
        build(5'h01, 5'h12, 1, msg31);
        v0 = nvalid;
        p0 = npkt;
        send_range(0, 2, -1, 8'h00);
        check("p1_err_b2", 32'(bus.err), 32'd1);
        send_range(2, 31, -1, 8'h00);
        check("p1_err_b31", 32'(bus.err), 32'd1);
        send_range(31, 32, -1, 8'h00);
        check("p1_err_b32", 32'(bus.err), 32'd0);
        check("p1_cnt_b32", 32'(bus.byte_cnt), 32'd32);
        repeat (2) @(posedge clk);
        #1;
        check("p1_no_valid", 32'(nvalid - v0), 32'd0);
        check("p1_no_done", 32'(npkt - p0), 32'd0);
        check("p1_rx", 32'(rx.size()), 32'd0);
        build(5'h01, 5'h12, 8, msg24);
        send_range(0, 32, -1, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("p1_next_done", 32'(npkt - p0), 32'd1);
        check_rx("p1_next", msg24, 24);

        // Preamble byte 4 with bits[6:5]=00.
        p0 = npkt;
        pkt[3] = pkt[3] & 8'h9F;
        send_range(0, 4, -1, 8'h00);
        check("pe_err", 32'(bus.err), 32'd1);
        send_range(4, 32, -1, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("pe_err_end", 32'(bus.err), 32'd0);
        check("pe_no_done", 32'(npkt - p0), 32'd0);
        check("pe_rx", 32'(rx.size()), 32'd0);

        // bit7=0 on message byte 6: only bytes 1..5 come out.
        build(5'h01, 5'h12, 8, msg24);
        pkt[13] = pkt[13] & 8'h7F;
        send_range(0, 14, -1, 8'h00);
        check("me_err", 32'(bus.err), 32'd1);
        send_range(14, 32, -1, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("me_no_done", 32'(npkt - p0), 32'd0);
        check_rx("me", msg24, 5);

        // Reset at message byte 15, then a back-to-back packet with a new key.
        build(5'h01, 5'h12, 8, msg24);
        send_range(0, 22, -1, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mr_byte_cnt", 32'(bus.byte_cnt), 32'd0);
        check("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check("mr_in_ready", 32'(bus.in_ready), 32'd1);
        rx.delete();
        p0 = npkt;
        build(5'h1F, 5'h14, 8, msg24);
        send_range(0, 32, -1, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("k2_seed", 32'(bus.seed_found), 32'h1F);
        check("k2_taps", 32'(bus.taps_found), 32'h14);
        check("k2_done", 32'(npkt - p0), 32'd1);
        check_rx("k2", msg24, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
